// File: rtl/imm_gen_q.sv
// Decode-stage immediate extender feeding a small valid/ready FIFO, so decode
// and execute can run decoupled. A flush drops everything queued on redirect.
module imm_gen_q #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t           mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0] imm32_next;
  logic        err_next;
  entry_t      entry_next;
  logic        push;
  logic        pop;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_inst[6:0];

  // Every format fits in a 32-bit sign-extended value; widening to XLEN is a
  // plain sign extension (zimm has bit 31 clear, so it stays zero-extended).
  always_comb begin
    imm32_next = '0;
    err_next   = 1'b0;
    unique case (in_type)
      3'd0: imm32_next = '0;
      3'd1: imm32_next = {{20{in_inst[31]}}, in_inst[31:20]};
      3'd2: imm32_next = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      3'd3: imm32_next = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
      3'd4: imm32_next = {in_inst[31:12], 12'b0};
      3'd5: imm32_next = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
      3'd6: imm32_next = {27'b0, in_inst[19:15]};
      default: begin
        imm32_next = '0;
        err_next   = 1'b1;
      end
    endcase
  end

  assign entry_next.imm = XLEN'($signed(imm32_next));
  assign entry_next.tag = in_tag;
  assign entry_next.err = err_next;

  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_imm = mem_reg[rd_ptr_reg].imm;
  assign out_tag = mem_reg[rd_ptr_reg].tag;
  assign out_err = mem_reg[rd_ptr_reg].err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage clears on reset so the head reads zero, but survives a flush.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (!flush && push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= entry_next;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_imm_gen_q.sv
// Scoreboard bench for imm_gen_q: one XLEN=32 and one XLEN=64 instance share
// the same stimulus; each has its own expected queue and monitor.
module tb_imm_gen_q;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_type;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  imm_gen_q #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_q #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
    .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks = 0;
  int   fails  = 0;
  int   pops64 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Holds the instruction until accepted; the expected result is queued at
  // the handshake edge.
  task automatic send(input logic [31:0] inst, input logic [2:0] typ,
                      input logic [31:0] tag, input logic [63:0] imm64,
                      input logic err);
    exp_t e;
    bit   done = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_type  = typ;
    in_tag   = tag;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready64) begin
        e.imm = imm64; e.tag = tag; e.err = err;
        q64.push_back(e);
        e.imm = {32'b0, imm64[31:0]};
        q32.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: inst %h never accepted, required acceptance", inst);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_inst  = '0;
    in_type  = '0;
    in_tag   = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_ready && out_valid64) begin
      pops64++;
      if (q64.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected64: got tag %h, required no output", out_tag64);
      end else begin
        e = q64.pop_front();
        $display("pop64 imm=%h tag=%h err=%0d", out_imm64, out_tag64, out_err64);
        chk("imm64", out_imm64, e.imm);
        chk("tag64", {32'b0, out_tag64}, {32'b0, e.tag});
        chk("err64", {63'b0, out_err64}, {63'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_ready && out_valid32) begin
      if (q32.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected32: got tag %h, required no output", out_tag32);
      end else begin
        e = q32.pop_front();
        $display("pop32 imm=%h tag=%h err=%0d", out_imm32, out_tag32, out_err32);
        chk("imm32", {32'b0, out_imm32}, e.imm);
        chk("tag32", {32'b0, out_tag32}, {32'b0, e.tag});
        chk("err32", {63'b0, out_err32}, {63'b0, e.err});
      end
    end
  end

  // Occupancy bookkeeping: count bounded by DEPTH and consistent with pointers.
  always @(negedge clk) begin
    logic [0:0] diff;
    if (rst_n) begin
      diff = dut64.wr_ptr_reg - dut64.rd_ptr_reg;
      chk("cnt_bound", {63'b0, dut64.count_reg <= 2'd2}, 64'd1);
      chk("cnt_ptr", {63'b0, dut64.count_reg[0]}, {63'b0, diff});
    end
  end

  initial begin
    int p0;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid64}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready64},  64'd1);
    chk("rst_out_imm",   out_imm64, 64'd0);
    chk("rst_out_tag",   {32'b0, out_tag64}, 64'd0);
    chk("rst_out_err",   {63'b0, out_err64}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single I-type, one-cycle latency then empty.
    send(32'hFFF00093, 3'd1, 32'h100, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    idle();
    @(negedge clk);
    chk("lat_valid32", {63'b0, out_valid32}, 64'd1);
    chk("lat_imm32",   {32'b0, out_imm32}, 64'h00000000_FFFFFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_valid", {63'b0, out_valid64}, 64'd0);
    @(posedge clk); #1;

    // Back-to-back stream; four pops in four cycles means no bubbles.
    p0 = pops64;
    send(32'hFE112E23, 3'd2, 32'h201, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    send(32'hFE000CE3, 3'd3, 32'h202, 64'hFFFFFFFF_FFFFFFF8, 1'b0);
    send(32'h001000EF, 3'd5, 32'h203, 64'h00000000_00000800, 1'b0);
    send(32'h000F5073, 3'd6, 32'h204, 64'h00000000_0000001E, 1'b0);
    idle();
    @(negedge clk); #1;
    chk("no_bubbles", 64'(pops64 - p0), 64'd4);
    @(posedge clk); #1;

    // U / R / illegal.
    send(32'h800000B7, 3'd4, 32'h301, 64'hFFFFFFFF_80000000, 1'b0);
    send(32'h002081B3, 3'd0, 32'h302, 64'h0, 1'b0);
    send(32'hFFFFFFFF, 3'd7, 32'h303, 64'h0, 1'b1);
    idle();
    repeat (3) @(posedge clk); #1;

    // Backpressure: two accepted, third held until a pop frees a slot.
    out_ready = 1'b0;
    send(32'h00100093, 3'd1, 32'h401, 64'h1, 1'b0);
    send(32'h00200093, 3'd1, 32'h402, 64'h2, 1'b0);
    in_valid = 1'b1; in_inst = 32'h00300093; in_type = 3'd1; in_tag = 32'h403;
    @(negedge clk);
    chk("full_in_ready", {63'b0, in_ready64}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_no_room", {63'b0, in_ready64}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00300093, 3'd1, 32'h403, 64'h3, 1'b0);
    idle();
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Flush with two queued and a push attempt.
    out_ready = 1'b0;
    send(32'h00500093, 3'd1, 32'h501, 64'h5, 1'b0);
    send(32'h00600093, 3'd1, 32'h502, 64'h6, 1'b0);
    flush = 1'b1; in_inst = 32'h00700093; in_tag = 32'h503;
    @(posedge clk); #1;
    flush = 1'b0; idle();
    q32.delete(); q64.delete();
    @(negedge clk);
    chk("flush_valid", {63'b0, out_valid64}, 64'd0);
    chk("flush_ready", {63'b0, in_ready64},  64'd1);
    @(posedge clk); #1;

    // Flush with one queued: the otherwise-acceptable push must be dropped.
    send(32'h00800093, 3'd1, 32'h601, 64'h8, 1'b0);
    flush = 1'b1; in_inst = 32'h00900093; in_tag = 32'h602;
    @(posedge clk); #1;
    flush = 1'b0; idle();
    q32.delete(); q64.delete();
    @(negedge clk);
    chk("flush1_valid", {63'b0, out_valid64}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00A00093, 3'd1, 32'h603, 64'hA, 1'b0);
    idle();
    repeat (3) @(posedge clk); #1;

    // Reset mid-stream.
    out_ready = 1'b0;
    send(32'h00B00093, 3'd1, 32'h701, 64'hB, 1'b0);
    send(32'h00C00093, 3'd1, 32'h702, 64'hC, 1'b0);
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q32.delete(); q64.delete();
    @(negedge clk);
    chk("mrst_valid", {63'b0, out_valid64}, 64'd0);
    chk("mrst_ready", {63'b0, in_ready64},  64'd1);
    chk("mrst_imm",   out_imm64, 64'd0);
    chk("mrst_tag",   {32'b0, out_tag64}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00D00093, 3'd1, 32'h801, 64'hD, 1'b0);
    idle();

    for (int k = 0; k < 100 && (q64.size() != 0 || q32.size() != 0); k++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain64", 64'(q64.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
